mac_sat_pipe: RTL
=================

# mac_sat_pipe

Pipelined, parametrised SIMD multiply-accumulate/subtract unit with signed saturation and a valid/ready handshake. Each accumulator lane takes one selected signed element from each of two multiplicand registers, forms the double-width product, adds or subtracts the matching accumulator lane, and optionally saturates. It sits in the multimedia execution stage beside the combinational R4 ALU ops. It is the multi-cycle, back-pressure-aware successor for long multiply-add/subtract instructions.

## Interface
Parameters:
- REG_WIDTH, 128: register width; must be a multiple of 2*ELEM_WIDTH.
- ELEM_WIDTH, 32: multiplicand element width. Accumulator/result lane width is ACC_WIDTH = 2*ELEM_WIDTH.
- STAGES, 3: pipeline depth in registers; minimum 2.
- Derived: LANES = REG_WIDTH/ACC_WIDTH.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operand beat valid.
- in_ready  out  1  unit accepts the beat this cycle.
- ctrl  in  3  per-beat control:
  - [0] element select: 0 = low element, 1 = high element of each ACC lane.
  - [1] 0 = product + rs1, 1 = product − rs1.
  - [2] saturate enable.
- reg_rs1  in  REG_WIDTH  accumulator operand, LANES signed ACC_WIDTH lanes.
- reg_rs2, reg_rs3  in  REG_WIDTH  multiplicands, 2*LANES signed ELEM_WIDTH elements.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- reg_rd  out  REG_WIDTH  result lanes.
- sat_lane  out  LANES  per-lane flag: this result was clamped. Qualified by out_valid.
- sat_status  out  LANES  sticky saturation status. Available only with the macro.
- sat_clr  in  1  clears sat_status. Available only with the macro.

## Operation
- Lane g uses element index 2g+ctrl[0] of rs2 and rs3. Both elements are sign-extended. The product is the full signed ACC_WIDTH value.
- rs1 lane g is [(g+1)*ACC_WIDTH-1 : g*ACC_WIDTH].
- Sum/difference is computed at ACC_WIDTH+1 bits signed.
  - ctrl[2]=1: clamp to [−2^(ACC_WIDTH−1), 2^(ACC_WIDTH−1)−1].
  - ctrl[2]=0: wrap, keeping the low ACC_WIDTH bits.
  - sat_lane[g] is 1 only when a clamp occurred.
- Pipeline structure:
  - Stage 1 registers ctrl, rs1 and the LANES products.
  - The final stage registers the add/sub/saturate result.
  - Intermediate stages are pass-through and may be retimed, but the observable latency is fixed.
- Elastic pipeline, one valid bit per stage:
  - A stage loads when its successor is empty or advancing.
  - Output stage advances when out_ready=1 or out_valid=0.
  - in_ready is 1 when stage 1 is empty or advancing.
  - Holding out_ready=0 fills all STAGES slots, then in_ready drops.
  - No beat is dropped or duplicated.
- A transfer occurs on a cycle with in_valid&in_ready (input) or out_valid&out_ready (output).
- While out_valid=1 and out_ready=0, reg_rd and sat_lane hold stable.
- in_valid may drop without a transfer; the inputs are then ignored.

## Timing
- Latency: a beat accepted at edge N appears with out_valid=1 after edge N+STAGES−1, i.e. STAGES cycles from presentation, when there is no stall.
- Throughput: one beat per cycle when out_ready is held at 1.
- Simultaneous input and output transfer in a full pipeline: both occur; occupancy is unchanged.
- Reset values: out_valid 0, reg_rd 0, sat_lane 0, sat_status 0, all stage valid bits 0. in_ready is 1 one cycle after reset deasserts.
- Reset mid-operation discards all in-flight beats immediately (asynchronous).

## Configuration
- MAC_SAT_STATUS_EN defined:
  - sat_status[g] sets when a lane-g result with sat_lane[g]=1 transfers out.
  - It clears on sat_clr.
  - If clear and set occur in the same cycle, set wins.
- MAC_SAT_STATUS_EN undefined: the sat_status and sat_clr ports and their logic are absent.

## Test plan
All scenarios use the default parameters.
- Lane 0, ctrl=3'b100, rs2 elem0=0x7FFFFFFF, rs3 elem0=0x7FFFFFFF, rs1 lane0=0x7FFFFFFFFFFFFFFF -> reg_rd lane0=0x7FFFFFFFFFFFFFFF, sat_lane=2'b01, out_valid 3 cycles after acceptance.
- Same operands with ctrl=3'b000 -> lane0=0xBFFFFFFF00000000 (wrapped), sat_lane=0.
- Lane 1, ctrl=3'b111, rs2 elem3=0x80000000, rs3 elem3=0x7FFFFFFF, rs1 lane1=0x7FFFFFFFFFFFFFFF -> lane1=0x8000000000000000, sat_lane=2'b10.
- Back-to-back stream of 8 beats with out_ready toggling 1,0,0,1…:
  - all 8 results arrive in order, matching the model;
  - in_ready falls after 3 stalled beats;
  - reg_rd is stable during stalls.
- Assert rst_n=0 with 3 beats in flight -> out_valid=0 immediately; no stale result appears after release.
- With MAC_SAT_STATUS_EN:
  - a saturating beat sets sat_status=2'b01;
  - sat_clr in the same cycle as a second saturating transfer leaves it at 2'b01;
  - sat_clr alone clears it to 0.

Source files
------------

// File: rtl/mac_sat_pipe.sv
// Elastic SIMD multiply-accumulate/subtract pipeline with signed saturation.
// Define MAC_SAT_STATUS_EN to add sticky sat_status with sat_clr.
module mac_sat_pipe #(
  parameter int REG_WIDTH  = 128,
  parameter int ELEM_WIDTH = 32,
  parameter int STAGES     = 3,
  localparam int ACC_WIDTH = 2 * ELEM_WIDTH,
  localparam int LANES     = REG_WIDTH / ACC_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [2:0]           ctrl,
  input  logic [REG_WIDTH-1:0] reg_rs1,
  input  logic [REG_WIDTH-1:0] reg_rs2,
  input  logic [REG_WIDTH-1:0] reg_rs3,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [REG_WIDTH-1:0] reg_rd,
  output logic [LANES-1:0]     sat_lane
`ifdef MAC_SAT_STATUS_EN
  ,
  output logic [LANES-1:0]     sat_status,
  input  logic                 sat_clr
`endif
);

  typedef struct packed {
    logic                 sub;
    logic                 sat;
    logic [REG_WIDTH-1:0] rs1;
    logic [REG_WIDTH-1:0] prod;
  } beat_t;

  beat_t [STAGES-2:0]   pl_q;
  beat_t                beat_d;
  beat_t                tail;
  logic [STAGES-1:0]    v_q;
  logic [STAGES-1:0]    en;
  logic [STAGES-1:0]    vin;
  logic [REG_WIDTH-1:0] rd_q;
  logic [REG_WIDTH-1:0] rd_d;
  logic [LANES-1:0]     satl_q;
  logic [LANES-1:0]     satl_d;

  // A stage can load unless it and every stage after it are full
  // while the consumer is stalling.
  always_comb begin : ready_chain
    logic full;
    full = 1'b1;
    en   = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      full  = full & v_q[k];
      en[k] = out_ready | ~full;
    end
  end

  assign vin = {v_q[STAGES-2:0], in_valid};

  always_comb begin : mul
    logic signed [ELEM_WIDTH-1:0] ea;
    logic signed [ELEM_WIDTH-1:0] eb;
    logic signed [ACC_WIDTH-1:0]  a;
    logic signed [ACC_WIDTH-1:0]  b;
    int sel;
    beat_d     = '0;
    ea         = '0;
    eb         = '0;
    a          = '0;
    b          = '0;
    sel        = 0;
    beat_d.sub = ctrl[1];
    beat_d.sat = ctrl[2];
    beat_d.rs1 = reg_rs1;
    for (int g = 0; g < LANES; g++) begin
      sel = 2 * g + int'(ctrl[0]);
      ea  = reg_rs2[sel*ELEM_WIDTH +: ELEM_WIDTH];
      eb  = reg_rs3[sel*ELEM_WIDTH +: ELEM_WIDTH];
      a   = ACC_WIDTH'(ea);
      b   = ACC_WIDTH'(eb);
      beat_d.prod[g*ACC_WIDTH +: ACC_WIDTH] = a * b;
    end
  end

  always_comb begin : acc
    logic signed [ACC_WIDTH:0] p;
    logic signed [ACC_WIDTH:0] r;
    logic signed [ACC_WIDTH:0] s;
    tail   = pl_q[STAGES-2];
    rd_d   = '0;
    satl_d = '0;
    p      = '0;
    r      = '0;
    s      = '0;
    for (int g = 0; g < LANES; g++) begin
      p = {tail.prod[g*ACC_WIDTH+ACC_WIDTH-1],
           tail.prod[g*ACC_WIDTH +: ACC_WIDTH]};
      r = {tail.rs1[g*ACC_WIDTH+ACC_WIDTH-1],
           tail.rs1[g*ACC_WIDTH +: ACC_WIDTH]};
      s = tail.sub ? p - r : p + r;
      if (tail.sat && (s[ACC_WIDTH] ^ s[ACC_WIDTH-1])) begin
        satl_d[g] = 1'b1;
        rd_d[g*ACC_WIDTH +: ACC_WIDTH] = s[ACC_WIDTH] ?
          {1'b1, {(ACC_WIDTH-1){1'b0}}} :
          {1'b0, {(ACC_WIDTH-1){1'b1}}};
      end else begin
        rd_d[g*ACC_WIDTH +: ACC_WIDTH] = s[ACC_WIDTH-1:0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q    <= '0;
      pl_q   <= '0;
      rd_q   <= '0;
      satl_q <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (en[k]) v_q[k] <= vin[k];
      end
      if (en[0] && in_valid) pl_q[0] <= beat_d;
      for (int k = 1; k < STAGES - 1; k++) begin
        if (en[k] && v_q[k-1]) pl_q[k] <= pl_q[k-1];
      end
      if (en[STAGES-1] && v_q[STAGES-2]) begin
        rd_q   <= rd_d;
        satl_q <= satl_d;
      end
    end
  end

  assign in_ready  = en[0];
  assign out_valid = v_q[STAGES-1];
  assign reg_rd    = rd_q;
  assign sat_lane  = satl_q;

`ifdef MAC_SAT_STATUS_EN
  logic [LANES-1:0] stat_q;
  logic [LANES-1:0] stat_d;

  // Set has priority over a coincident clear.
  always_comb begin
    stat_d = sat_clr ? '0 : stat_q;
    if (out_valid && out_ready) stat_d = stat_d | satl_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stat_q <= '0;
    else        stat_q <= stat_d;
  end

  assign sat_status = stat_q;
`endif

endmodule
